// File: rtl/dmem_lanes.sv
// Four-lane byte-organised data memory with a single-entry registered response,
// load sign/zero extension, alignment/range checking and a saturating error counter.
module dmem_lanes #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  err_count
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    // Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
    // the response register is a one-deep buffer, so a request is taken only when it is
    // empty or being drained in the same cycle.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_t;

    rsp_state_t        state;
    logic              accept;
    logic              bad;
    logic              in_range;
    logic              wr_en;
    logic [ADDR_W-3:0] word_idx;
    logic [IDX_W-1:0]  idx;
    logic [3:0]        lane_en;
    logic [31:0]       lane_wdata;
    logic [31:0]       rd_word;
    logic [31:0]       rd_shift;
    logic [31:0]       ld_data;

    assign rsp_valid = (state == FULL);
    assign req_ready = !rst && (!rsp_valid || rsp_ready);
    assign accept    = req_valid && req_ready;

    assign word_idx = req_addr[ADDR_W-1:2];
    assign idx      = word_idx[IDX_W-1:0];
    assign in_range = ((word_idx >> IDX_W) == '0);

    always_comb begin
        bad = 1'b0;
        case (req_size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = req_addr[0];
            2'd2:    bad = (req_addr[1:0] != 2'b00);
            default: bad = 1'b1;
        endcase
        if (!in_range) bad = 1'b1;
    end

    // Store data is replicated across lanes so each bank simply takes its own byte slice.
    always_comb begin
        lane_en    = 4'b0000;
        lane_wdata = req_wdata;
        case (req_size)
            2'd0: begin
                lane_en    = 4'b0001 << req_addr[1:0];
                lane_wdata = {4{req_wdata[7:0]}};
            end
            2'd1: begin
                lane_en    = req_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{req_wdata[15:0]}};
            end
            2'd2:    lane_en = 4'b1111;
            default: lane_en = 4'b0000;
        endcase
    end

    assign wr_en = accept && req_we && !bad;

    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [7:0] bank [DEPTH_WORDS];

        always_ff @(posedge clk) begin
            if (wr_en && lane_en[k]) bank[idx] <= lane_wdata[8*k +: 8];
        end

        assign rd_word[8*k +: 8] = bank[idx];
    end

    // Legal halfwords have addr[0] = 0, so one byte-granular shift serves both sizes.
    assign rd_shift = rd_word >> {req_addr[1:0], 3'b000};

    always_comb begin
        ld_data = rd_word;
        case (req_size)
            2'd0:    ld_data = req_unsigned ? {24'h0, rd_shift[7:0]}
                                            : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'd1:    ld_data = req_unsigned ? {16'h0, rd_shift[15:0]}
                                            : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: ld_data = rd_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            err_count <= '0;
        end else if (accept) begin
            state     <= FULL;
            rsp_err   <= bad;
            rsp_rdata <= (bad || req_we) ? '0 : ld_data;
            if (bad && (err_count != '1)) err_count <= err_count + 1'b1;
        end else if (rsp_ready) begin
            state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_dmem_lanes.sv
// Bench for dmem_lanes: directed vector table, hand-written backpressure/reset sequences,
// and randomized traffic checked against a byte-addressed reference model.
module tb_dmem_lanes;

    localparam int AW    = 32;
    localparam int DEPTH = 64;
    localparam int CW    = 4;
    localparam int BYTES = 4 * DEPTH;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [CW-1:0] err_count;

    dmem_lanes #(.ADDR_W(AW), .DEPTH_WORDS(DEPTH), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .err_count    (err_count)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: each entry is {rsp_err, rsp_rdata}
    logic [32:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  mref [0:BYTES-1];
    int          ecnt  = 0;
    logic        rand_bp = 1'b0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic mon();
        logic [32:0] e;
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", {rsp_err, rsp_rdata}, 33'h1_DEAD_0000);
            end else begin
                e = exp_q.pop_front();
                chk("rsp", {rsp_err, rsp_rdata}, e);
            end
        end
    endtask

    // One clock: sample and score at the falling edge, return 1 time unit after the rising edge.
    task automatic step(output logic rdy);
        @(negedge clk);
        rdy = req_ready;
        mon();
        @(posedge clk);
        #1;
    endtask

    // Reference model: byte-addressed memory, rules applied directly to addresses.
    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [32:0] res);
        int          nb;
        logic        err;
        logic [31:0] val;
        nb  = 1 << size;
        err = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
              (size == 2'd2 && (addr % 4) != 0) || (addr >= BYTES);
        val = '0;
        if (err) begin
            if (ecnt < (1 << CW) - 1) ecnt++;
            res = {1'b1, 32'h0};
        end else if (we) begin
            for (int j = 0; j < nb; j++) mref[addr + j] = wdata[8*j +: 8];
            res = '0;
        end else begin
            for (int j = 0; j < nb; j++) val = val | (32'(mref[addr + j]) << (8 * j));
            if (!uns && nb < 4 && val[8*nb-1]) val = val | ~((32'h1 << (8 * nb)) - 1);
            res = {1'b0, val};
        end
    endtask

    // driver: hold the request until accepted, then queue its expected response
    task automatic send(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic has_exp, input logic [32:0] exp_v);
        logic        rdy;
        logic        done;
        logic [32:0] m;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        done         = 1'b0;
        for (int w = 0; w < 60 && !done; w++) begin
            if (rand_bp) rsp_ready = ($urandom_range(0, 3) != 0);
            step(rdy);
            if (rdy) begin
                done = 1'b1;
                model(we, size, uns, addr, wdata, m);
                exp_q.push_back(has_exp ? exp_v : m);
            end
        end
        if (!done) chk("req_timeout", 33'h0, 33'h1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        logic rdy;
        rsp_ready = 1'b1;
        for (int w = 0; w < 20 && exp_q.size() != 0; w++) step(rdy);
        chk("drain", 33'(exp_q.size()), 33'h0);
    endtask

    initial begin
        logic rdy;
        int   t0;
        logic [1:0]  rs;
        logic [31:0] ra;

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;

        vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'h8899AABB, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        1'b0, 32'h8899AABB};
        vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h21,  32'h00000080, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h21,  32'h0,        1'b0, 32'hFFFFFF80};
        vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h21,  32'h0,        1'b0, 32'h00000080};
        vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h20,  32'h0,        1'b0, 32'h08088008};
        vecs[6]  = '{1'b1, 2'd1, 1'b0, 32'h32,  32'h0000F00D, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 2'd1, 1'b0, 32'h32,  32'h0,        1'b0, 32'hFFFFF00D};
        vecs[8]  = '{1'b0, 2'd2, 1'b0, 32'h30,  32'h0,        1'b0, 32'hF00D0C0C};
        vecs[9]  = '{1'b0, 2'd1, 1'b1, 32'h32,  32'h0,        1'b0, 32'h0000F00D};
        vecs[10] = '{1'b1, 2'd1, 1'b0, 32'h41,  32'h0000BEEF, 1'b1, 32'h0};
        vecs[11] = '{1'b1, 2'd2, 1'b0, 32'h42,  32'hCAFEBABE, 1'b1, 32'h0};
        vecs[12] = '{1'b1, 2'd3, 1'b0, 32'h40,  32'hFFFFFFFF, 1'b1, 32'h0};
        vecs[13] = '{1'b1, 2'd2, 1'b0, BYTES,   32'h12345678, 1'b1, 32'h0};
        vecs[14] = '{1'b0, 2'd2, 1'b0, 32'h40,  32'h0,        1'b0, 32'h10101010};
        vecs[15] = '{1'b0, 2'd0, 1'b0, 32'h43,  32'h0,        1'b0, 32'h00000010};
        vecs[16] = '{1'b0, 2'd2, 1'b0, BYTES-4, 32'h0,        1'b0, 32'h3F3F3F3F};

        // reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_rsp_valid", 33'(rsp_valid), 33'h0);
        chk("rst_rsp_data",  {rsp_err, rsp_rdata}, 33'h0);
        chk("rst_err_count", 33'(err_count), 33'h0);
        chk("rst_req_ready", 33'(req_ready), 33'h0);
        rst = 1'b0;

        // known background: word i holds byte value i in every lane
        for (int i = 0; i < DEPTH; i++) send(1'b1, 2'd2, 1'b0, 32'(4 * i), {4{8'(i)}}, 1'b0, '0);
        drain();

        // directed vectors
        for (int i = 0; i < 17; i++) begin
            send(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                 1'b1, {vecs[i].err, vecs[i].rdata});
            if (i == 1) chk("load_latency", 33'(rsp_valid), 33'h1);
        end
        drain();
        chk("err_count_4", 33'(err_count), 33'd4);

        // backpressure: response held, new request refused
        rsp_ready = 1'b0;
        send(1'b0, 2'd2, 1'b0, 32'h10, '0, 1'b1, {1'b0, 32'h8899AABB});
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h60; req_wdata = 32'h55555555;
        for (int k = 0; k < 5; k++) begin
            step(rdy);
            chk("bp_no_accept", 33'(rdy), 33'h0);
            chk("bp_hold", {rsp_valid, rsp_rdata}, {1'b1, 32'h8899AABB});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        t0 = cyc;
        send(1'b0, 2'd2, 1'b0, 32'h10, '0, 1'b1, {1'b0, 32'h8899AABB});
        send(1'b0, 2'd2, 1'b0, 32'h20, '0, 1'b1, {1'b0, 32'h08088008});
        send(1'b0, 2'd2, 1'b0, 32'h30, '0, 1'b1, {1'b0, 32'hF00D0C0C});
        chk("b2b_cycles", 33'(cyc - t0), 33'd3);
        send(1'b0, 2'd2, 1'b0, 32'h60, '0, 1'b1, {1'b0, 32'h18181818});
        drain();

        // reset with a pending response and a store on the request port
        rsp_ready = 1'b0;
        send(1'b0, 2'd2, 1'b0, 32'h10, '0, 1'b1, {1'b0, 32'h8899AABB});
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h50; req_wdata = 32'hDEADBEEF;
        rst = 1'b1;
        exp_q.delete();
        ecnt = 0;
        step(rdy);
        chk("rst_mid_accept", 33'(rdy), 33'h0);
        chk("rst_mid_valid", 33'(rsp_valid), 33'h0);
        chk("rst_mid_data", {rsp_err, rsp_rdata}, 33'h0);
        chk("rst_mid_count", 33'(err_count), 33'h0);
        step(rdy);
        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
        send(1'b0, 2'd2, 1'b0, 32'h50, '0, 1'b1, {1'b0, 32'h14141414});
        drain();

        // randomized traffic with random backpressure
        rand_bp = 1'b1;
        for (int n = 0; n < 400; n++) begin
            rs = 2'($urandom_range(0, 3));
            ra = $urandom_range(0, BYTES + 15);
            if ($urandom_range(0, 2) != 0) ra = ra & ~((32'h1 << rs) - 1);
            if ($urandom_range(0, 4) == 0) begin
                rsp_ready = ($urandom_range(0, 1) != 0);
                step(rdy);
            end
            send(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom, 1'b0, '0);
        end
        rand_bp = 1'b0;
        drain();
        chk("rand_err_count", 33'(err_count), 33'(ecnt));

        // saturation
        for (int n = 0; n < 20; n++) send(1'b0, 2'd3, 1'b0, 32'h0, '0, 1'b0, '0);
        drain();
        chk("err_count_sat", 33'(err_count), 33'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
